// File: rtl/rt_pkg.sv
// Shared ray-tracer types: fixed-point widths and the hit record passed
// from the hit writer to the accumulate stage.
package rt_pkg;

  localparam int Q_BITS = 10;
  localparam int D_BITS = 32;
  localparam int M_BITS = 12;

  typedef struct packed {
    logic                   hit;
    logic [2:0][D_BITS-1:0] p_hit;
    logic [M_BITS-1:0]      tri_id;
    logic                   last;
  } hit_rec_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DRAIN
  } hw_state_e;

endpackage

// File: rtl/hit_buffer.sv
// Small synchronous first-word-fall-through FIFO of hit records.
module hit_buffer
  import rt_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  hit_rec_t                   push_rec,
  input  logic                       pop,
  output hit_rec_t                   head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  hit_rec_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  // Storage array; contents are don't-care while their slot is empty.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_rec;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/hit_writer.sv
// Producer end of the hit-record FIFO: buffers per-triangle results,
// tags each ray's final record, optionally filters misses, pulses ray_done.
module hit_writer
  import rt_pkg::*;
#(
  parameter int Q_BITS    = rt_pkg::Q_BITS,
  parameter int D_BITS    = rt_pkg::D_BITS,
  parameter int M_BITS    = rt_pkg::M_BITS,
  parameter int NUM_TRI   = 1024,
  parameter int BUF_DEPTH = 4,
  parameter int DROP_MISS = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_hit,
  input  logic signed [D_BITS-1:0] in_p_hit [3],
  input  logic [M_BITS-1:0]        in_tri_id,
  input  logic                     out_full,
  output logic                     out_wr_en,
  output logic                     out_hit,
  output logic signed [D_BITS-1:0] out_p_hit [3],
  output logic [M_BITS-1:0]        out_tri_id,
  output logic                     out_last,
  output logic                     ray_done,
  output logic                     seq_err
);

  localparam int                CW      = $clog2(BUF_DEPTH) + 1;
  localparam logic [M_BITS-1:0] LAST_ID = M_BITS'(NUM_TRI - 1);

  // Coordinates are carried as raw bits; the fraction width only documents
  // the format, and a format without integer bits has no meaning here.
  if (Q_BITS >= D_BITS) begin : g_q_bits_no_integer_part
  end

  hw_state_e         state;
  hw_state_e         state_nxt;
  logic [M_BITS-1:0] tri_cnt;
  logic [CW-1:0]     buf_count;
  logic              buf_nonempty;
  hit_rec_t          head;
  hit_rec_t          rec;
  logic              accept;
  logic              is_last;
  logic              enq;
  logic              ray_done_nxt;

  assign buf_nonempty = (buf_count != '0);
  assign in_ready     = (state != ST_DRAIN) && (buf_count != CW'(BUF_DEPTH));
  assign accept       = in_valid && in_ready;
  assign is_last      = (tri_cnt == LAST_ID);
  assign enq          = accept && ((DROP_MISS == 0) || in_hit || is_last);
  assign out_wr_en    = buf_nonempty && !out_full;

  // Build the record to enqueue; a filtered-mode miss carries a zero point.
  always_comb begin
    rec        = '0;
    rec.hit    = in_hit;
    rec.tri_id = in_tri_id;
    rec.last   = is_last;
    for (int unsigned i = 0; i < 3; i++) begin
      rec.p_hit[i] = in_p_hit[i];
    end
    if ((DROP_MISS != 0) && !in_hit) begin
      rec.p_hit = '0;
    end
  end

  hit_buffer #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clock    (clock),
    .reset    (reset),
    .push     (enq),
    .push_rec (rec),
    .pop      (out_wr_en),
    .head     (head),
    .count    (buf_count)
  );

  // Present the buffer head; an empty buffer reads as all zero.
  always_comb begin
    out_hit    = 1'b0;
    out_tri_id = '0;
    out_last   = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      out_p_hit[i] = '0;
    end
    if (buf_nonempty) begin
      out_hit    = head.hit;
      out_tri_id = head.tri_id;
      out_last   = head.last;
      for (int unsigned i = 0; i < 3; i++) begin
        out_p_hit[i] = head.p_hit[i];
      end
    end
  end

  // Ray sequencing: next state and the end-of-ray pulse.
  always_comb begin
    state_nxt    = state;
    ray_done_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) state_nxt = is_last ? ST_DRAIN : ST_STREAM;
      end
      ST_STREAM: begin
        if (accept && is_last) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (out_wr_en && head.last) begin
          state_nxt    = ST_IDLE;
          ray_done_nxt = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register and registered ray_done pulse.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= ST_IDLE;
      ray_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      ray_done <= ray_done_nxt;
    end
  end

  // Triangle sequence counter and sticky ordering error.
  always_ff @(posedge clock) begin
    if (!reset) begin
      tri_cnt <= '0;
      seq_err <= 1'b0;
    end else if (accept) begin
      tri_cnt <= is_last ? '0 : tri_cnt + 1'b1;
      if (in_tri_id != tri_cnt) seq_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hit_writer.sv
// Directed bench for hit_writer: three instances cover NUM_TRI=4 unfiltered,
// NUM_TRI=4 miss-filtered and NUM_TRI=1. One row = one clock cycle.
module tb_hit_writer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic               reset;
  logic               valid [3];
  logic               full  [3];
  logic               in_hit;
  logic [11:0]        in_id;
  logic signed [31:0] p_in [3];

  logic               rdy [3], wr [3], ohit [3], olast [3], done [3], err [3];
  logic [11:0]        oid [3];
  logic signed [31:0] op0 [3], op1 [3], op2 [3];

  hit_writer #(.NUM_TRI(4), .BUF_DEPTH(4), .DROP_MISS(0)) dut0 (
    .clock(clock), .reset(reset), .in_valid(valid[0]), .in_ready(rdy[0]),
    .in_hit(in_hit), .in_p_hit(p_in), .in_tri_id(in_id), .out_full(full[0]),
    .out_wr_en(wr[0]), .out_hit(ohit[0]), .out_p_hit(op0), .out_tri_id(oid[0]),
    .out_last(olast[0]), .ray_done(done[0]), .seq_err(err[0]));

  hit_writer #(.NUM_TRI(4), .BUF_DEPTH(4), .DROP_MISS(1)) dut1 (
    .clock(clock), .reset(reset), .in_valid(valid[1]), .in_ready(rdy[1]),
    .in_hit(in_hit), .in_p_hit(p_in), .in_tri_id(in_id), .out_full(full[1]),
    .out_wr_en(wr[1]), .out_hit(ohit[1]), .out_p_hit(op1), .out_tri_id(oid[1]),
    .out_last(olast[1]), .ray_done(done[1]), .seq_err(err[1]));

  hit_writer #(.NUM_TRI(1), .BUF_DEPTH(4), .DROP_MISS(0)) dut2 (
    .clock(clock), .reset(reset), .in_valid(valid[2]), .in_ready(rdy[2]),
    .in_hit(in_hit), .in_p_hit(p_in), .in_tri_id(in_id), .out_full(full[2]),
    .out_wr_en(wr[2]), .out_hit(ohit[2]), .out_p_hit(op2), .out_tri_id(oid[2]),
    .out_last(olast[2]), .ray_done(done[2]), .seq_err(err[2]));

  typedef struct {
    int                 sel;
    logic               rst, v, hit;
    logic [11:0]        id;
    logic signed [31:0] z;
    logic               full;
    logic               e_rdy, e_wr;
    logic [11:0]        e_id;
    logic               e_last, e_hit;
    logic signed [31:0] e_z;
    logic               e_done, e_err, chkd;
  } row_t;

  int nvec = 0;
  int nerr = 0;

  function automatic row_t mk(int sel, logic rst, logic v, logic hit, logic [11:0] id,
                              logic signed [31:0] z, logic fl, logic e_rdy, logic e_wr,
                              logic [11:0] e_id, logic e_last, logic e_hit,
                              logic signed [31:0] e_z, logic e_done, logic e_err, logic chkd);
    row_t r;
    r.sel = sel; r.rst = rst; r.v = v; r.hit = hit; r.id = id; r.z = z; r.full = fl;
    r.e_rdy = e_rdy; r.e_wr = e_wr; r.e_id = e_id; r.e_last = e_last; r.e_hit = e_hit;
    r.e_z = e_z; r.e_done = e_done; r.e_err = e_err; r.chkd = chkd;
    return r;
  endfunction

  task automatic chk(input string nm, input int n, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s (row %0d): got %0d, want %0d", nm, n, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check outputs before the edge, then clock.
  task automatic step(input row_t r);
    logic               a_rdy, a_wr, a_hit, a_last, a_done, a_err;
    logic [11:0]        a_id;
    logic signed [31:0] a_x, a_y, a_z;
    logic signed [31:0] ex;
    reset = r.rst;
    for (int d = 0; d < 3; d++) begin
      valid[d] = (d == r.sel) ? r.v    : 1'b0;
      full[d]  = (d == r.sel) ? r.full : 1'b0;
    end
    in_hit  = r.hit;
    in_id   = r.id;
    p_in[0] = r.z + 1;
    p_in[1] = -r.z;
    p_in[2] = r.z;
    #1;
    case (r.sel)
      0:       begin a_x = op0[0]; a_y = op0[1]; a_z = op0[2]; end
      1:       begin a_x = op1[0]; a_y = op1[1]; a_z = op1[2]; end
      default: begin a_x = op2[0]; a_y = op2[1]; a_z = op2[2]; end
    endcase
    a_rdy = rdy[r.sel]; a_wr = wr[r.sel]; a_hit = ohit[r.sel]; a_last = olast[r.sel];
    a_done = done[r.sel]; a_err = err[r.sel]; a_id = oid[r.sel];
    chk("in_ready", nvec, a_rdy, r.e_rdy);
    chk("out_wr_en", nvec, a_wr, r.e_wr);
    chk("ray_done", nvec, a_done, r.e_done);
    chk("seq_err", nvec, a_err, r.e_err);
    if (r.chkd) begin
      ex = (r.e_z == 0) ? 32'sd0 : r.e_z + 1;
      chk("out_tri_id", nvec, a_id, r.e_id);
      chk("out_last", nvec, a_last, r.e_last);
      chk("out_hit", nvec, a_hit, r.e_hit);
      chk("out_p_hit_x", nvec, a_x, ex);
      chk("out_p_hit_y", nvec, a_y, -r.e_z);
      chk("out_p_hit_z", nvec, a_z, r.e_z);
    end
    nvec++;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    row_t tbl [$];

    // dut0: four back-to-back results, then an out-of-order id sequence 0,1,5,3
    tbl.push_back(mk(0,1,1,1,0,-1024,0, 1,0,0,0,0,0,     0,0,0));
    tbl.push_back(mk(0,1,1,1,1,-1024,0, 1,1,0,0,1,-1024, 0,0,1));
    tbl.push_back(mk(0,1,1,1,2,-1024,0, 1,1,1,0,1,-1024, 0,0,1));
    tbl.push_back(mk(0,1,1,1,3,-1024,0, 1,1,2,0,1,-1024, 0,0,1));
    tbl.push_back(mk(0,1,0,0,0,-9,   0, 0,1,3,1,1,-1024, 0,0,1));
    tbl.push_back(mk(0,1,0,0,0,-9,   0, 1,0,0,0,0,0,     1,0,1));
    tbl.push_back(mk(0,1,0,0,0,-9,   0, 1,0,0,0,0,0,     0,0,1));
    tbl.push_back(mk(0,1,1,1,0,-2048,0, 1,0,0,0,0,0,     0,0,0));
    tbl.push_back(mk(0,1,1,0,1,-2048,0, 1,1,0,0,1,-2048, 0,0,1));
    tbl.push_back(mk(0,1,1,1,5,-2048,0, 1,1,1,0,0,-2048, 0,0,1));
    tbl.push_back(mk(0,1,1,1,3,-2048,0, 1,1,5,0,1,-2048, 0,1,1));
    tbl.push_back(mk(0,1,0,0,0,-9,   0, 0,1,3,1,1,-2048, 0,1,1));
    tbl.push_back(mk(0,1,0,0,0,-9,   0, 1,0,0,0,0,0,     1,1,1));
    // dut1: miss filter, hit pattern 0,1,0,0
    tbl.push_back(mk(1,1,1,0,0,-300, 0, 1,0,0,0,0,0,     0,0,1));
    tbl.push_back(mk(1,1,1,1,1,-300, 0, 1,0,0,0,0,0,     0,0,1));
    tbl.push_back(mk(1,1,1,0,2,-300, 0, 1,1,1,0,1,-300,  0,0,1));
    tbl.push_back(mk(1,1,1,0,3,-300, 0, 1,0,0,0,0,0,     0,0,1));
    tbl.push_back(mk(1,1,0,0,0,-9,   0, 0,1,3,1,0,0,     0,0,1));
    tbl.push_back(mk(1,1,0,0,0,-9,   0, 1,0,0,0,0,0,     1,0,1));
    tbl.push_back(mk(1,1,0,0,0,-9,   0, 1,0,0,0,0,0,     0,0,1));
    // dut2: single-triangle ray; valid held while ready is low must not accept
    tbl.push_back(mk(2,1,1,1,0,777,  0, 1,0,0,0,0,0,     0,0,0));
    tbl.push_back(mk(2,1,1,1,0,555,  0, 0,1,0,1,1,777,   0,0,1));
    tbl.push_back(mk(2,1,0,0,0,-9,   0, 1,0,0,0,0,0,     1,0,1));
    tbl.push_back(mk(2,1,0,0,0,-9,   0, 1,0,0,0,0,0,     0,0,1));

    reset = 1'b0;
    in_hit = 1'b0;
    in_id = '0;
    for (int d = 0; d < 3; d++) begin
      valid[d] = 1'b0;
      full[d]  = 1'b0;
      p_in[d]  = '0;
    end
    repeat (2) @(posedge clock);
    #1;

    // Post-reset state of every instance.
    for (int d = 0; d < 3; d++) step(mk(d,1,0,0,0,-9,0, 1,0,0,0,0,0, 0,0,1));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Reset during DRAIN with two records buffered (seq_err still set from above).
    for (int k = 0; k < 4; k++) step(mk(0,1,1,1,12'(k),-500,1, 1,0,0,0,0,0, 0,1,0));
    for (int k = 0; k < 2; k++) step(mk(0,1,0,1,0,-500,0, 0,1,12'(k),0,1,-500, 0,1,1));
    step(mk(0,1,0,1,0,-500,1, 0,0,0,0,0,0, 0,1,0));
    step(mk(0,0,0,1,0,-500,1, 0,0,0,0,0,0, 0,1,0));
    step(mk(0,1,0,1,0,-500,0, 1,0,0,0,0,0, 0,0,1));
    step(mk(0,1,0,1,0,-500,0, 1,0,0,0,0,0, 0,0,1));

    // Fresh ray under 10 cycles of backpressure, then release and drain in order.
    for (int k = 0; k < 10; k++)
      step(mk(0,1,1,1, (k < 4) ? 12'(k) : 12'd0, -100 * (k + 1), 1,
              (k < 4) ? 1'b1 : 1'b0, 0,0,0,0,0, 0,0,0));
    for (int k = 0; k < 4; k++)
      step(mk(0,1,0,1,0,-1,0, 0,1,12'(k),(k == 3) ? 1'b1 : 1'b0,1,-100 * (k + 1), 0,0,1));
    step(mk(0,1,0,0,0,-9,0, 1,0,0,0,0,0, 1,0,1));
    step(mk(0,1,0,0,0,-9,0, 1,0,0,0,0,0, 0,0,1));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/hit_writer.md
Name: hit_writer

Overview:
- Producer end of the hit-record FIFO drained by the accumulate stage.
- Accepts per-triangle intersection results from the intersection core over valid/ready and buffers them locally.
- Writes them into the downstream FIFO under its full flag, tags the final record of each ray with out_last, and pulses ray_done once that record is written.
- Optionally filters misses so the accumulate stage only sees useful records.

Parameters:
- Q_BITS, 10: fractional bits of fixed-point coordinates; pass-through only, no arithmetic.
- D_BITS, 32: signed coordinate width.
- M_BITS, 12: triangle ID width.
- NUM_TRI, 1024: triangles per ray; legal range 1..2^M_BITS.
- BUF_DEPTH, 4: local buffer entries; power of two, at least 2.
- DROP_MISS, 0: when 1, miss records are not written, except a ray's final record.

Ports:
- clock  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  intersection result valid.
- in_ready  out  1  hit_writer can accept a result this cycle.
- in_hit  in  1  ray hit the triangle.
- in_p_hit  in  3 x D_BITS signed  hit point x,y,z (index 0..2).
- in_tri_id  in  M_BITS  triangle index of this result.
- out_full  in  1  downstream FIFO full.
- out_wr_en  out  1  write strobe to downstream FIFO.
- out_hit  out  1  record hit flag.
- out_p_hit  out  3 x D_BITS signed  record hit point.
- out_tri_id  out  M_BITS  record triangle index.
- out_last  out  1  record is the ray's final record.
- ray_done  out  1  one-cycle pulse when the final record of a ray is written.
- seq_err  out  1  sticky: in_tri_id differed from the expected count.

Behaviour:
- Reset (reset==0 at a clock edge) takes precedence over all activity, including mid-ray and mid-drain:
  - buffer emptied; tri_cnt=0; state=IDLE; seq_err=0; ray_done=0.
  - out_wr_en is 0 because the buffer is empty; out_* data and out_last read 0.
- Accept: a result is accepted in a cycle where in_valid && in_ready.
  - in_ready = (state != DRAIN) && (buffer count < BUF_DEPTH).
  - in_ready is computed from registered state only; it never depends combinationally on in_valid or out_full.
- Sequence counter tri_cnt:
  - Increments on every accept, whether or not the result is enqueued.
  - If in_tri_id != tri_cnt on an accept, seq_err sets and stays set until reset; the record is still processed normally.
- Last detection: an accept with tri_cnt == NUM_TRI-1 is the ray's last result. That record is enqueued with last=1; tri_cnt returns to 0.
- Enqueue rule:
  - DROP_MISS=0: every accepted result is enqueued.
  - DROP_MISS=1: enqueue only if in_hit==1 or the result is last. A last miss is enqueued with hit=0, p_hit=0, last=1.
- Write side (first-word-fall-through):
  - out_wr_en = buffer non-empty && !out_full, combinational.
  - out_hit, out_p_hit, out_tri_id and out_last show the buffer head; the head pops on the cycle out_wr_en=1.
  - The downstream full flag is honoured in the cycle it is asserted.
- Same-cycle accept and write: allowed when the buffer is not full. The count is unchanged, and order is preserved (strict FIFO).
- A full buffer blocks an accept even if a pop occurs the same cycle.
- State machine:
  - IDLE: tri_cnt==0 and no ray in progress. First accept -> STREAM, or -> DRAIN if NUM_TRI==1.
  - STREAM: accepts results; accept of the last result -> DRAIN.
  - DRAIN: in_ready=0. On the cycle the last=1 record is written (out_wr_en && out_last), register ray_done=1 for exactly one cycle and go -> IDLE.
- Latency:
  - With an empty buffer and out_full=0, an accepted result appears with out_wr_en=1 in the cycle after the accept.
  - ray_done is asserted in the cycle after the last record is written.
- Throughput: one record per cycle sustained when out_full stays low.
- No arithmetic: coordinates pass unmodified and keep their sign.

Decomposition:
- Shared package rt_pkg holds:
  - constants D_BITS, Q_BITS, M_BITS.
  - typedef hit_rec_t {hit, p_hit[3], tri_id, last}, shared with the accumulate stage's read side.
- One sub-module, hit_buffer: a synchronous FWFT FIFO of hit_rec_t, with parameter DEPTH, push/pop/count ports, and reset of the same polarity.
- FSM, counter, filter and seq_err stay in hit_writer.

Test Plan:
- NUM_TRI=4, DROP_MISS=0, out_full=0, four back-to-back results (ids 0..3, p_hit z=-1024) -> four writes on consecutive cycles; out_last only on id 3; z reads -1024; ray_done one cycle after id 3 is written; in_ready=0 between the last accept and ray_done.
- DROP_MISS=1, NUM_TRI=4, hit pattern 0,1,0,0 -> exactly two writes: id 1 (hit=1, last=0), then id 3 (hit=0, p_hit=0, last=1).
- BUF_DEPTH=4, out_full held 1 for 10 cycles while in_valid=1 -> in_ready falls after 4 accepts, out_wr_en=0 throughout; after out_full drops, records 0..3 emerge in order.
- in_tri_id sequence 0,1,5,3 -> seq_err rises the cycle after id 5 is accepted and stays 1; all four records are still written, last on the 4th.
- reset=0 for one cycle during DRAIN with 2 records buffered -> next cycle: out_wr_en=0, in_ready=1, tri_cnt=0, seq_err=0, no ray_done pulse; a fresh ray starting at id 0 then completes normally.
- NUM_TRI=1, single accepted hit -> one write with last=1; state goes IDLE->DRAIN->IDLE; ray_done pulses once.
